// File: rtl/uart_word_sender.sv
// ---------------------------------------------------------------------------
// uart_word_sender
//   Streams 32-bit words from the core back to the host over a UART line.
//   Words enter through a valid/ready handshake into a small FIFO. Each word
//   goes out as four back-to-back serial frames, most significant byte first,
//   each byte LSB first (8N1, or 8E1 when parity is compiled in).
//
//   Optional feature: define UART_WORD_SENDER_PARITY_EN to insert an even
//   parity bit between the data bits and the stop bit (8E1 frames).
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (>= 2)
//   FIFO_DEPTH   : word FIFO entries (power of two, >= 2)
//
// Ports
//   CLK        : system clock, rising edge
//   RST        : synchronous active-high reset
//   word_in    : word to transmit
//   word_valid : word_in is valid
//   word_ready : FIFO can accept a word (fifo_count < FIFO_DEPTH)
//   UART_TX    : serial line, idle high
//   busy       : FIFO non-empty or a frame in flight
//   fifo_count : words buffered, excluding the word being sent
// ---------------------------------------------------------------------------
module uart_word_sender #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [31:0]                 word_in,
    input  logic                        word_valid,
    output logic                        word_ready,
    output logic                        UART_TX,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
`ifdef UART_WORD_SENDER_PARITY_EN
        ,PARITY = 3'd4
`endif
    } state_t;

    // Byte lane select: index 0 is the most significant byte.
    function automatic logic [7:0] select_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            2'd3:    b = w[7:0];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

`ifdef UART_WORD_SENDER_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t          state_r, state_s;
    logic [BW-1:0]   baud_r, baud_s;
    logic [2:0]      bit_idx_r, bit_idx_s;
    logic [1:0]      byte_idx_r, byte_idx_s;
    logic [31:0]     shift_r, shift_s;
    logic [31:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]   count_r, count_s;
    logic            tx_r, tx_s, busy_r, ready_r;
    logic            push_s, pop_s, wrap_s, fifo_empty_s;
    logic [7:0]      cur_byte_s;

    // ready_r is exactly (count_r < FIFO_DEPTH), so a full FIFO refuses the
    // word even when a pop happens on the same edge.
    assign push_s       = word_valid && ready_r;
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign wrap_s       = (baud_r == BW'(CLKS_PER_BIT - 1));

    assign UART_TX    = tx_r;
    assign busy       = busy_r;
    assign word_ready = ready_r;
    assign fifo_count = count_r;

    // Next-state logic: bit sequencing, byte sequencing and FIFO pops.
    always_comb begin
        state_s    = state_r;
        bit_idx_s  = bit_idx_r;
        byte_idx_s = byte_idx_r;
        shift_s    = shift_r;
        pop_s      = 1'b0;
        if (state_r == IDLE || wrap_s) begin
            baud_s = {BW{1'b0}};
        end else begin
            baud_s = baud_r + BW'(1'b1);
        end
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    shift_s    = mem_r[rd_ptr_r];
                    byte_idx_s = 2'd0;
                    bit_idx_s  = 3'd0;
                    state_s    = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (wrap_s) begin
                    bit_idx_s = 3'd0;
                    state_s   = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (wrap_s && bit_idx_r == 3'd7) begin
                    bit_idx_s = 3'd0;
`ifdef UART_WORD_SENDER_PARITY_EN
                    state_s   = PARITY;
`else
                    state_s   = STOP;
`endif
                end else if (wrap_s) begin
                    bit_idx_s = bit_idx_r + 3'd1;
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_WORD_SENDER_PARITY_EN
            PARITY: begin
                if (wrap_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (wrap_s && byte_idx_r != 2'd3) begin
                    byte_idx_s = byte_idx_r + 2'd1;
                    state_s    = START;
                end else if (wrap_s && !fifo_empty_s) begin
                    // Chain straight into the next queued word, no idle gap.
                    pop_s      = 1'b1;
                    shift_s    = mem_r[rd_ptr_r];
                    byte_idx_s = 2'd0;
                    state_s    = START;
                end else if (wrap_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so UART_TX is a clean register.
    always_comb begin
        cur_byte_s = select_byte(shift_s, byte_idx_s);
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = cur_byte_s[bit_idx_s];
`ifdef UART_WORD_SENDER_PARITY_EN
            PARITY:  tx_s = even_parity(cur_byte_s);
`endif
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // FIFO occupancy: push and pop on the same edge cancel out.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CW'(1'b1);
            2'b01:   count_s = count_r - CW'(1'b1);
            default: count_s = count_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, FIFO storage and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            baud_r     <= {BW{1'b0}};
            bit_idx_r  <= 3'd0;
            byte_idx_r <= 2'd0;
            shift_r    <= 32'd0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            ready_r    <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else begin
            baud_r     <= baud_s;
            bit_idx_r  <= bit_idx_s;
            byte_idx_r <= byte_idx_s;
            shift_r    <= shift_s;
            count_r    <= count_s;
            tx_r       <= tx_s;
            busy_r     <= (state_s != IDLE) || (count_s != {CW{1'b0}});
            ready_r    <= (count_s < CW'(FIFO_DEPTH));
            if (push_s) begin
                mem_r[wr_ptr_r] <= word_in;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
        end
    end
endmodule

// File: tb/tb_uart_word_sender.sv
// ---------------------------------------------------------------------------
// tb_uart_word_sender
//   Self-checking bench for uart_word_sender (CLKS_PER_BIT=4, FIFO_DEPTH=4).
//   Reference model: a word queue plus a countdown of the current word's
//   transmit time; the expected line level is derived from the frame layout.
//   The line is also captured and decoded independently at mid-bit.
// ---------------------------------------------------------------------------
module tb_uart_word_sender;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_WORD_SENDER_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME_CYC = FB * CPB;
    localparam int WORD_CYC  = 4 * FRAME_CYC;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] word_in = 32'd0;
    logic        word_valid = 1'b0;
    logic        word_ready, UART_TX, busy;
    logic [2:0]  fifo_count;

    uart_word_sender #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .UART_TX(UART_TX), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passed = 0;
    int cyc = 0;

    // reference model state
    logic [31:0] m_q[$];
    int          m_rem = 0;
    int          m_el = 0;
    logic [31:0] m_cur = 32'd0;
    bit          m_acc = 1'b0;

    // stimulus and capture
    logic [31:0] pend_q[$];
    logic        cap_q[$];
    logic [31:0] dec_q[$];
    int          dec_bad = 0;

    function automatic logic exp_tx();
        int b, fr, pos;
        logic [7:0] by;
        if (m_rem == 0) return 1'b1;
        b   = m_el / CPB;
        fr  = b / FB;
        pos = b % FB;
        by  = 8'((m_cur >> (8 * (3 - fr))) & 32'hFF);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return by[pos-1];
        if (FB == 11 && pos == 9) return ^by;
        return 1'b1;
    endfunction

    function automatic logic exp_busy();
        return (m_rem != 0) || (m_q.size() != 0);
    endfunction

    function automatic logic [2:0] exp_cnt();
        return 3'(m_q.size());
    endfunction

    function automatic logic exp_ready();
        return m_q.size() < DEPTH;
    endfunction

    task automatic model_step();
        int pre;
        pre   = m_q.size();
        m_acc = 1'b0;
        if (RST) begin
            m_q.delete();
            m_rem = 0;
            m_el  = 0;
        end else begin
            if (m_rem > 0) begin
                m_rem--;
                m_el++;
            end
            if (m_rem == 0 && pre != 0) begin
                m_cur = m_q.pop_front();
                m_rem = WORD_CYC;
                m_el  = 0;
            end
            if (word_valid && pre < DEPTH) begin
                m_q.push_back(word_in);
                m_acc = 1'b1;
            end
        end
    endtask

    task automatic tick();
        word_valid = (pend_q.size() != 0);
        word_in    = (pend_q.size() != 0) ? pend_q[0] : 32'd0;
        @(posedge CLK);
        model_step();
        #1;
        cyc++;
        if (m_acc) void'(pend_q.pop_front());
        cap_q.push_back(UART_TX);
    endtask

    task automatic decode_stream();
        int i, base;
        logic [31:0] w;
        logic [7:0] by;
        bit ok;
        dec_q.delete();
        dec_bad = 0;
        i = 0;
        while (i < cap_q.size()) begin
            if (cap_q[i] == 1'b0) begin
                if (i + WORD_CYC > cap_q.size()) begin
                    dec_bad++;
                    break;
                end
                ok = 1'b1;
                w  = 32'd0;
                for (int f = 0; f < 4; f++) begin
                    base = i + f * FRAME_CYC;
                    for (int k = 0; k < 8; k++) by[k] = cap_q[base + (k + 1) * CPB + CPB / 2];
                    if (cap_q[base + CPB / 2] != 1'b0 || cap_q[base + (FB - 1) * CPB + CPB / 2] != 1'b1) ok = 1'b0;
                    if (FB == 11 && cap_q[base + 9 * CPB + CPB / 2] != ^by) ok = 1'b0;
                    w = {w[23:0], by};
                end
                if (!ok) dec_bad++;
                dec_q.push_back(w);
                i += WORD_CYC;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        pend_q.push_back($urandom());
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (UART_TX !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0 || word_ready !== 1'b1)
                $display("FAIL reset_values cyc=%0d tx=%b busy=%b cnt=%0d rdy=%b, want 1 0 0 1", cyc, UART_TX, busy, fifo_count, word_ready);
            else passed++;
        end
        pend_q.delete();
        RST = 1'b0;
        for (int i = 0; i < 2 * CPB; i++) begin
            tick();
            checks++;
            if (UART_TX !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0)
                $display("FAIL reset_no_accept cyc=%0d tx=%b busy=%b cnt=%0d, want 1 0 0", cyc, UART_TX, busy, fifo_count);
            else passed++;
        end
    endtask

    task automatic test_single_word();
        int n;
        cap_q.delete();
        pend_q.push_back(32'hDEADBEEF);
        tick();
        checks++;
        if (UART_TX !== 1'b1 || fifo_count !== 3'd1 || busy !== 1'b1)
            $display("FAIL single_accept tx=%b cnt=%0d busy=%b, want 1 1 1", UART_TX, fifo_count, busy);
        else passed++;
        tick();
        checks++;
        if (UART_TX !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL single_latency tx=%b cnt=%0d, want 0 0", UART_TX, fifo_count);
        else passed++;
        n = 0;
        while (busy !== 1'b0 && n < WORD_CYC + 20) begin
            tick();
            n++;
            checks++;
            if (UART_TX !== exp_tx() || busy !== exp_busy() || fifo_count !== exp_cnt() || word_ready !== exp_ready())
                $display("FAIL model_single cyc=%0d got tx=%b busy=%b cnt=%0d rdy=%b want tx=%b busy=%b cnt=%0d rdy=%b",
                         cyc, UART_TX, busy, fifo_count, word_ready, exp_tx(), exp_busy(), exp_cnt(), exp_ready());
            else passed++;
        end
        checks++;
        if (n != WORD_CYC) $display("FAIL single_duration cycles=%0d, want %0d", n, WORD_CYC);
        else passed++;
        decode_stream();
        checks++;
        if (dec_q.size() != 1 || dec_bad != 0 || dec_q[0] !== 32'hDEADBEEF)
            $display("FAIL single_decode words=%0d bad=%0d first=%h, want 1 0 deadbeef", dec_q.size(), dec_bad, (dec_q.size() != 0) ? dec_q[0] : 32'hx);
        else passed++;
    endtask

    task automatic test_full_fifo();
        logic [31:0] w[6];
        int n, c_f, c_6, max_cnt;
        cap_q.delete();
        for (int i = 0; i < 6; i++) begin
            w[i] = $urandom();
            pend_q.push_back(w[i]);
        end
        n = 0; c_f = -1; c_6 = -1; max_cnt = 0;
        while ((busy !== 1'b0 || pend_q.size() != 0 || n == 0) && n < 6 * WORD_CYC + 50) begin
            tick();
            n++;
            if (c_f < 0 && UART_TX === 1'b0) c_f = cyc;
            if (m_acc && pend_q.size() == 0) c_6 = cyc;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            checks++;
            if (UART_TX !== exp_tx() || busy !== exp_busy() || fifo_count !== exp_cnt() || word_ready !== exp_ready())
                $display("FAIL model_full cyc=%0d got tx=%b busy=%b cnt=%0d rdy=%b want tx=%b busy=%b cnt=%0d rdy=%b",
                         cyc, UART_TX, busy, fifo_count, word_ready, exp_tx(), exp_busy(), exp_cnt(), exp_ready());
            else passed++;
            if (fifo_count === 3'd4) begin
                checks++;
                if (word_ready !== 1'b0) $display("FAIL full_ready cyc=%0d rdy=%b, want 0", cyc, word_ready);
                else passed++;
            end
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL full_timeout busy=%b after %0d cycles, want 0", busy, n);
        else passed++;
        checks++;
        if (max_cnt != DEPTH) $display("FAIL full_max_count got=%0d want=%0d", max_cnt, DEPTH);
        else passed++;
        checks++;
        if (c_6 != c_f + WORD_CYC + 1) $display("FAIL full_sixth_accept cyc=%0d want=%0d", c_6, c_f + WORD_CYC + 1);
        else passed++;
        decode_stream();
        checks++;
        if (dec_q.size() != 6 || dec_bad != 0) $display("FAIL full_decode words=%0d bad=%0d, want 6 0", dec_q.size(), dec_bad);
        else passed++;
        for (int i = 0; i < 6 && i < dec_q.size(); i++) begin
            checks++;
            if (dec_q[i] !== w[i]) $display("FAIL full_order idx=%0d got=%h want=%h", i, dec_q[i], w[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] c;
        int n;
        pend_q.push_back($urandom());
        pend_q.push_back($urandom());
        n = 0;
        while (UART_TX !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (UART_TX !== 1'b0) $display("FAIL mid_start tx=%b, want 0", UART_TX);
        else passed++;
        for (int k = 1; k <= (FB + 4) * CPB + 1; k++) begin
            tick();
            checks++;
            if (UART_TX !== exp_tx() || busy !== exp_busy() || fifo_count !== exp_cnt())
                $display("FAIL model_mid cyc=%0d got tx=%b busy=%b cnt=%0d want tx=%b busy=%b cnt=%0d",
                         cyc, UART_TX, busy, fifo_count, exp_tx(), exp_busy(), exp_cnt());
            else passed++;
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (UART_TX !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0)
            $display("FAIL mid_reset tx=%b cnt=%0d busy=%b, want 1 0 0", UART_TX, fifo_count, busy);
        else passed++;
        cap_q.delete();
        c = $urandom();
        pend_q.push_back(c);
        n = 0;
        while ((busy !== 1'b0 || pend_q.size() != 0 || n == 0) && n < WORD_CYC + 20) begin
            tick();
            n++;
        end
        decode_stream();
        checks++;
        if (dec_q.size() != 1 || dec_bad != 0 || dec_q[0] !== c)
            $display("FAIL mid_after words=%0d bad=%0d first=%h want=%h", dec_q.size(), dec_bad, (dec_q.size() != 0) ? dec_q[0] : 32'hx, c);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[3];
        int n, c_f;
        cap_q.delete();
        for (int i = 0; i < 3; i++) w[i] = $urandom();
        pend_q.push_back(w[0]);
        pend_q.push_back(w[1]);
        n = 0;
        while (UART_TX !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        c_f = cyc;
        while (cyc < c_f + WORD_CYC - 1) begin
            tick();
            checks++;
            if (UART_TX !== exp_tx() || fifo_count !== exp_cnt())
                $display("FAIL model_b2b cyc=%0d got tx=%b cnt=%0d want tx=%b cnt=%0d", cyc, UART_TX, fifo_count, exp_tx(), exp_cnt());
            else passed++;
        end
        checks++;
        if (fifo_count !== 3'd1) $display("FAIL b2b_before cnt=%0d, want 1", fifo_count);
        else passed++;
        pend_q.push_back(w[2]);
        tick();
        checks++;
        if (fifo_count !== 3'd1 || UART_TX !== 1'b0)
            $display("FAIL b2b_push_pop cnt=%0d tx=%b, want 1 0", fifo_count, UART_TX);
        else passed++;
        n = 0;
        while (busy !== 1'b0 && n < 3 * WORD_CYC) begin
            tick();
            n++;
        end
        decode_stream();
        checks++;
        if (dec_q.size() != 3 || dec_bad != 0) $display("FAIL b2b_decode words=%0d bad=%0d, want 3 0", dec_q.size(), dec_bad);
        else passed++;
        for (int i = 0; i < 3 && i < dec_q.size(); i++) begin
            checks++;
            if (dec_q[i] !== w[i]) $display("FAIL b2b_order idx=%0d got=%h want=%h", i, dec_q[i], w[i]);
            else passed++;
        end
    endtask

    task automatic test_random_stream();
        logic [31:0] w[6];
        int n, gap;
        cap_q.delete();
        for (int i = 0; i < 6; i++) begin
            w[i] = $urandom();
            gap  = int'($urandom_range(0, WORD_CYC + 20));
            for (int g = 0; g < gap; g++) begin
                tick();
                checks++;
                if (UART_TX !== exp_tx() || busy !== exp_busy() || fifo_count !== exp_cnt() || word_ready !== exp_ready())
                    $display("FAIL model_rand cyc=%0d got tx=%b busy=%b cnt=%0d rdy=%b want tx=%b busy=%b cnt=%0d rdy=%b",
                             cyc, UART_TX, busy, fifo_count, word_ready, exp_tx(), exp_busy(), exp_cnt(), exp_ready());
                else passed++;
            end
            pend_q.push_back(w[i]);
        end
        n = 0;
        while ((busy !== 1'b0 || pend_q.size() != 0 || n == 0) && n < 7 * WORD_CYC) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL rand_timeout busy=%b, want 0", busy);
        else passed++;
        decode_stream();
        checks++;
        if (dec_q.size() != 6 || dec_bad != 0) $display("FAIL rand_decode words=%0d bad=%0d, want 6 0", dec_q.size(), dec_bad);
        else passed++;
        for (int i = 0; i < 6 && i < dec_q.size(); i++) begin
            checks++;
            if (dec_q[i] !== w[i]) $display("FAIL rand_order idx=%0d got=%h want=%h", i, dec_q[i], w[i]);
            else passed++;
        end
    endtask

`ifdef UART_WORD_SENDER_PARITY_EN
    task automatic test_parity();
        logic exp_par[4];
        int n, s;
        exp_par = '{1'b1, 1'b0, 1'b1, 1'b0};
        cap_q.delete();
        pend_q.push_back(32'h01030700);
        n = 0;
        while ((busy !== 1'b0 || pend_q.size() != 0 || n == 0) && n < WORD_CYC + 20) begin
            tick();
            n++;
        end
        s = 0;
        while (s < cap_q.size() && cap_q[s] != 1'b0) s++;
        for (int f = 0; f < 4; f++) begin
            checks++;
            if (s + (f + 1) * FRAME_CYC > cap_q.size() || cap_q[s + f * FRAME_CYC + 9 * CPB + CPB / 2] !== exp_par[f])
                $display("FAIL parity_bit frame=%0d want=%b", f, exp_par[f]);
            else passed++;
            if (f < 3) begin
                checks++;
                if (cap_q[s + (f + 1) * FRAME_CYC - 1] !== 1'b1 || cap_q[s + (f + 1) * FRAME_CYC] !== 1'b0)
                    $display("FAIL parity_frame_len frame=%0d, want stop then start at %0d cycles", f, FRAME_CYC);
                else passed++;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_full_fifo();
        test_reset_mid();
        test_back_to_back();
        test_random_stream();
`ifdef UART_WORD_SENDER_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
